// File: rtl/adxl362_spi_responder_if.sv
// SPI bus bundle between an SPI master and the ADXL362 register responder.
interface adxl362_spi_responder_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, cs_n, mosi, input miso, miso_oe);
  modport slave  (input sclk, cs_n, mosi, output miso, miso_oe);
endinterface

// File: rtl/adxl362_spi_responder.sv
// ADXL362-style SPI register responder: mode-0 slave with ID/status/sample
// read map, a 0x20-0x2E register file, and burst read/write with pointer wrap.
module adxl362_spi_responder #(
  parameter logic [7:0] DEVID_AD = 8'hAD,
  parameter logic [7:0] PARTID   = 8'hF2
) (
  input  logic                          clk,
  input  logic                          rst,
  adxl362_spi_responder_if.slave        spi,
  input  logic [47:0]                   sample_data,
  input  logic                          sample_valid,
  output logic [7:0]                    power_ctl,
  output logic                          wr_strobe,
  output logic [5:0]                    wr_addr,
  output logic [7:0]                    wr_data
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;

  state_t      state, state_next;
  logic [1:0]  sclk_sync, cs_sync, mosi_sync;
  logic        sclk_prev, cs_prev, armed;
  logic [1:0]  warm;
  logic        sclk_s, cs_s, mosi_s;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic        shifting, byte_done, writable;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx;
  logic [7:0]  rx_next, shreg, rd_byte;
  logic [5:0]  ptr;
  logic        rd_mode, data_ready;
  logic [47:0] sample_reg, shadow;
  logic [7:0]  regs [15];

  assign sclk_s    = sclk_sync[1];
  assign cs_s      = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  // A fall only counts once cs_n has been seen high after reset
  assign cs_fall   = armed & cs_prev & ~cs_s;
  assign shifting  = (state inside {CMD, ADDR, WDATA, RDATA}) & ~cs_rise;
  assign byte_done = shifting & sclk_rise & (bit_cnt == 3'd7);
  assign rx_next   = {rx, mosi_s};
  assign writable  = (ptr >= 6'h20) && (ptr <= 6'h2E);
  assign power_ctl = regs[13];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      warm      <= '0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi.sclk};
      cs_sync   <= {cs_sync[0], spi.cs_n};
      mosi_sync <= {mosi_sync[0], spi.mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      warm      <= {warm[0], 1'b1};
      if (warm[1] && cs_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cs_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_next = CMD;
        CMD:     if (byte_done)
                   state_next = (rx_next == 8'h0A || rx_next == 8'h0B) ? ADDR : IGNORE;
        ADDR:    if (byte_done) state_next = rd_mode ? RDATA : WDATA;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    spi.miso    = (state == RDATA) ? shreg[7] : 1'b0;
    spi.miso_oe = ~cs_s;
  end

  always_comb begin
    rd_byte = '0;
    case (ptr)
      6'h00:   rd_byte = DEVID_AD;
      6'h01:   rd_byte = 8'h1D;
      6'h02:   rd_byte = PARTID;
      6'h0B:   rd_byte = {7'b0, data_ready};
      6'h0E:   rd_byte = shadow[7:0];
      6'h0F:   rd_byte = shadow[15:8];
      6'h10:   rd_byte = shadow[23:16];
      6'h11:   rd_byte = shadow[31:24];
      6'h12:   rd_byte = shadow[39:32];
      6'h13:   rd_byte = shadow[47:40];
      default: if (writable) rd_byte = regs[ptr[3:0]];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt    <= '0;
      rx         <= '0;
      shreg      <= '0;
      ptr        <= '0;
      rd_mode    <= 1'b0;
      data_ready <= 1'b0;
      sample_reg <= '0;
      shadow     <= '0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      for (int unsigned i = 0; i < 15; i++) regs[i] <= (i == 12) ? 8'h13 : 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (state == IDLE && cs_fall) begin
        bit_cnt <= '0;
        shadow  <= sample_reg;
      end else if (shifting && sclk_rise) begin
        rx      <= rx_next[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          case (state)
            CMD:   rd_mode <= (rx_next == 8'h0B);
            ADDR:  ptr <= rx_next[5:0];
            WDATA: begin
              if (writable) begin
                regs[ptr[3:0]] <= rx_next;
                wr_strobe      <= 1'b1;
                wr_addr        <= ptr;
                wr_data        <= rx_next;
              end
              ptr <= ptr + 6'd1;
            end
            default: ;
          endcase
        end
      end
      // Next read byte is fetched on the fall that ends the previous byte
      if (state == RDATA && !cs_rise) begin
        if (sclk_fall) begin
          if (bit_cnt == 3'd0) begin
            shreg <= rd_byte;
            ptr   <= ptr + 6'd1;
            if (ptr == 6'h0E) data_ready <= 1'b0;
          end else begin
            shreg <= {shreg[6:0], 1'b0};
          end
        end
      end else begin
        shreg <= '0;
      end
      if (sample_valid) begin
        sample_reg <= sample_data;
        data_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Directed bench for the ADXL362 SPI responder: a bit-banged mode-0 master
// with queued expected read bytes and expected register-write strobes.
module tb_adxl362_spi_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [47:0] sample_data = '0;
  logic        sample_valid = 1'b0;
  logic [7:0]  power_ctl, wr_data;
  logic        wr_strobe;
  logic [5:0]  wr_addr;

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_q[$];
  logic [13:0] exp_wr[$];
  logic [13:0] wr_log[$];

  adxl362_spi_responder_if spi_if ();

  adxl362_spi_responder #(.DEVID_AD(8'hAD), .PARTID(8'hF2)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi          (spi_if),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .power_ctl    (power_ctl),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_strobe) wr_log.push_back({wr_addr, wr_data});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_if.mosi = tx[i];
      #50;
      rx[i] = spi_if.miso;
      spi_if.sclk = 1'b1;
      #50;
      spi_if.sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi_if.cs_n = 1'b0;
    #100;
  endtask

  task automatic cs_end();
    #100;
    spi_if.cs_n = 1'b1;
    #200;
  endtask

  task automatic rd_pop(input string tag, input int idx);
    logic [7:0] rx;
    logic [7:0] e;
    spi_bits(8'h00, 8, rx);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
    check($sformatf("%s[%0d]", tag, idx), rx, e);
  endtask

  task automatic rd_check(input logic [5:0] addr, input int n, input string tag);
    logic [7:0] rx;
    cs_begin();
    spi_bits(8'h0B, 8, rx);
    check({tag, "_oe"}, spi_if.miso_oe, 1'b1);
    spi_bits({2'b00, addr}, 8, rx);
    for (int i = 0; i < n; i++) rd_pop(tag, i);
    cs_end();
  endtask

  task automatic wr_burst(input logic [7:0] b[4], input int n);
    logic [7:0] rx;
    cs_begin();
    for (int i = 0; i < n; i++) spi_bits(b[i], 8, rx);
    cs_end();
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, wr_log.size(), exp_wr.size());
    while (wr_log.size() > 0 && exp_wr.size() > 0)
      check({tag, "_addr_data"}, wr_log.pop_front(), exp_wr.pop_front());
    wr_log.delete();
    exp_wr.delete();
  endtask

  task automatic pulse_sample(input logic [47:0] d);
    @(negedge clk);
    sample_data  = d;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] acc;
    spi_if.sclk = 1'b0;
    spi_if.cs_n = 1'b1;
    spi_if.mosi = 1'b0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_miso", spi_if.miso, 1'b0);
    check("rst_miso_oe", spi_if.miso_oe, 1'b0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_wr_addr", wr_addr, 6'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_power_ctl", power_ctl, 8'h00);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    exp_q.push_back(8'h13);
    rd_check(6'h2C, 1, "filter_ctl_rst");
    exp_q.push_back(8'h00);
    rd_check(6'h0B, 1, "status_rst");

    exp_wr.push_back({6'h2D, 8'h02});
    wr_burst('{8'h0A, 8'h2D, 8'h02, 8'h00}, 3);
    check_writes("pwr_wr");
    @(negedge clk);
    check("power_ctl", power_ctl, 8'h02);

    exp_q.push_back(8'hAD); exp_q.push_back(8'h1D); exp_q.push_back(8'hF2);
    rd_check(6'h00, 3, "id");

    pulse_sample(48'h0A0B0C0D0E0F);
    exp_q.push_back(8'h01);
    rd_check(6'h0B, 1, "status_set");
    foreach (exp_q[i]) ;
    exp_q.push_back(8'h0F); exp_q.push_back(8'h0E); exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0C); exp_q.push_back(8'h0B); exp_q.push_back(8'h0A);
    rd_check(6'h0E, 6, "shadow");
    exp_q.push_back(8'h00);
    rd_check(6'h0B, 1, "status_clr");

    // New sample mid-burst must not disturb this burst
    exp_q.push_back(8'h0F); exp_q.push_back(8'h0E); exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0C); exp_q.push_back(8'h0B); exp_q.push_back(8'h0A);
    cs_begin();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h0E, 8, rx);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) pulse_sample(48'h111213141516);
      rd_pop("coherent", i);
    end
    cs_end();
    exp_q.push_back(8'h16); exp_q.push_back(8'h15); exp_q.push_back(8'h14);
    exp_q.push_back(8'h13); exp_q.push_back(8'h12); exp_q.push_back(8'h11);
    rd_check(6'h0E, 6, "new_sample");

    wr_burst('{8'h0A, 8'h3F, 8'h11, 8'h22}, 4);
    check_writes("wrap_wr");
    exp_q.push_back(8'h00); exp_q.push_back(8'hAD);
    rd_check(6'h3F, 2, "rd_wrap");

    exp_wr.push_back({6'h2E, 8'h55});
    wr_burst('{8'h0A, 8'h2E, 8'h55, 8'h66}, 4);
    check_writes("top_edge");
    exp_wr.push_back({6'h20, 8'h88});
    wr_burst('{8'h0A, 8'h1F, 8'h77, 8'h88}, 4);
    check_writes("low_edge");
    exp_q.push_back(8'h88);
    rd_check(6'h20, 1, "rd_20");
    exp_q.push_back(8'h55); exp_q.push_back(8'h00);
    rd_check(6'h2E, 2, "rd_2e");

    acc = '0;
    cs_begin();
    spi_bits(8'h0D, 8, rx);
    acc |= rx;
    for (int i = 0; i < 8; i++) begin
      spi_bits(8'($urandom_range(0, 255)), 8, rx);
      acc |= rx;
    end
    cs_end();
    check("ignore_miso", acc, 8'h00);
    check_writes("ignore_wr");

    cs_begin();
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h21, 8, rx);
    spi_bits(8'hF0, 4, rx);
    cs_end();
    check_writes("partial_wr");
    exp_q.push_back(8'h00);
    rd_check(6'h21, 1, "rd_21");

    // Reset during a read burst with cs_n held low afterwards
    cs_begin();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h2D, 8, rx);
    spi_bits(8'h00, 8, rx);
    check("pre_rst_read", rx, 8'h02);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_miso", spi_if.miso, 1'b0);
    check("mid_rst_miso_oe", spi_if.miso_oe, 1'b0);
    check("mid_rst_power_ctl", power_ctl, 8'h00);
    check("mid_rst_wr_addr", wr_addr, 6'h00);
    check("mid_rst_wr_data", wr_data, 8'h00);
    check("mid_rst_wr_strobe", wr_strobe, 1'b0);
    rst = 1'b1;
    #200;
    acc = '0;
    spi_bits(8'h0A, 8, rx); acc |= rx;
    spi_bits(8'h2D, 8, rx); acc |= rx;
    spi_bits(8'h05, 8, rx); acc |= rx;
    cs_end();
    check("post_rst_idle_miso", acc, 8'h00);
    check_writes("post_rst_idle_wr");
    check("post_rst_power_ctl", power_ctl, 8'h00);

    exp_wr.push_back({6'h2D, 8'h02});
    wr_burst('{8'h0A, 8'h2D, 8'h02, 8'h00}, 3);
    check_writes("post_rst_wr");
    exp_q.push_back(8'hAD); exp_q.push_back(8'h1D); exp_q.push_back(8'hF2);
    rd_check(6'h00, 3, "post_rst_id");
    exp_q.push_back(8'h13); exp_q.push_back(8'h02);
    rd_check(6'h2C, 2, "post_rst_regs");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
